// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one execute stage (operand mux + ALU)
// between two valid/ready requesters. One operation in flight at a time:
// IDLE grants and registers operands, EXEC lets the ALU settle and captures
// its result, RESP holds the result until the owner accepts it.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic [DATA_WIDTH-1:0] req_a_0,
  input  logic [DATA_WIDTH-1:0] req_a_1,
  input  logic [DATA_WIDTH-1:0] req_b_0,
  input  logic [DATA_WIDTH-1:0] req_b_1,
  input  logic [DATA_WIDTH-1:0] req_imm_0,
  input  logic [DATA_WIDTH-1:0] req_imm_1,
  input  logic [3:0]            req_ctrl_0,
  input  logic [3:0]            req_ctrl_1,
  input  logic                  req_src_0,
  input  logic                  req_src_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_0,
  input  logic                  rsp_ready_1,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [DATA_WIDTH-1:0] ex_reg_data1,
  output logic [DATA_WIDTH-1:0] ex_reg_data2,
  output logic [DATA_WIDTH-1:0] ex_imm_ext,
  output logic [3:0]            ex_ALUctrl,
  output logic                  ex_ALUsrc,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic                  ex_z_flag,
  input  logic                  ex_n_flag,
  input  logic                  ex_c_flag,
  input  logic                  ex_v_flag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   owner_q;
  logic   prio_q;

  logic   grant_sel;
  logic   hs;
  logic   rsp_ready_own;

  logic [DATA_WIDTH-1:0] ex_a_p1;
  logic [DATA_WIDTH-1:0] ex_b_p1;
  logic [DATA_WIDTH-1:0] ex_imm_p1;
  logic [3:0]            ex_ctrl_p1;
  logic                  ex_src_p1;
  logic [DATA_WIDTH-1:0] result_p2;
  logic [3:0]            flags_p2;

  // Grant selection: a lone requester wins outright, a tie goes to prio.
  // Handshake only in IDLE and never while reset is asserted.
  always_comb begin
    grant_sel     = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
    hs            = (state_q == IDLE) && !rst && (req_valid_0 || req_valid_1);
    rsp_ready_own = owner_q ? rsp_ready_1 : rsp_ready_0;
  end

  // State, owner and tie-break priority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= grant_sel;
        prio_q  <= ~grant_sel;
      end
    end
  end

  // Next-state logic: grant -> execute -> hold response until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_own) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state and owner.
  always_comb begin
    req_ready_0 = hs && !grant_sel;
    req_ready_1 = hs && grant_sel;
    rsp_valid_0 = (state_q == RESP) && !owner_q;
    rsp_valid_1 = (state_q == RESP) && owner_q;
    busy        = (state_q != IDLE);
  end

  // Stage 1 boundary: operands of the granted requester enter the execute stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_a_p1    <= '0;
      ex_b_p1    <= '0;
      ex_imm_p1  <= '0;
      ex_ctrl_p1 <= '0;
      ex_src_p1  <= 1'b0;
    end else if (hs) begin
      ex_a_p1    <= grant_sel ? req_a_1    : req_a_0;
      ex_b_p1    <= grant_sel ? req_b_1    : req_b_0;
      ex_imm_p1  <= grant_sel ? req_imm_1  : req_imm_0;
      ex_ctrl_p1 <= grant_sel ? req_ctrl_1 : req_ctrl_0;
      ex_src_p1  <= grant_sel ? req_src_1  : req_src_0;
    end
  end

  // Stage 2 boundary: capture the settled ALU result and flags at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (state_q == EXEC) begin
      result_p2 <= ex_alu_result;
      flags_p2  <= {ex_z_flag, ex_n_flag, ex_c_flag, ex_v_flag};
    end
  end

  assign ex_reg_data1 = ex_a_p1;
  assign ex_reg_data2 = ex_b_p1;
  assign ex_imm_ext   = ex_imm_p1;
  assign ex_ALUctrl   = ex_ctrl_p1;
  assign ex_ALUsrc    = ex_src_p1;
  assign rsp_result   = result_p2;
  assign rsp_flags    = flags_p2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table of single operations plus hand-written
// round-robin, backpressure and reset-during-execute sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1, req_imm_0, req_imm_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic        req_src_0, req_src_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] ex_reg_data1, ex_reg_data2, ex_imm_ext;
  logic [3:0]  ex_ALUctrl;
  logic        ex_ALUsrc;
  logic [31:0] ex_alu_result;
  logic [3:0]  tb_flags;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Execute-stage model: adder on the selected second operand, flags from the bench.
  assign ex_alu_result = ex_reg_data1 + (ex_ALUsrc ? ex_imm_ext : ex_reg_data2);

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_imm_0(req_imm_0), .req_imm_1(req_imm_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .req_src_0(req_src_0), .req_src_1(req_src_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .ex_reg_data1(ex_reg_data1), .ex_reg_data2(ex_reg_data2),
    .ex_imm_ext(ex_imm_ext), .ex_ALUctrl(ex_ALUctrl), .ex_ALUsrc(ex_ALUsrc),
    .ex_alu_result(ex_alu_result),
    .ex_z_flag(tb_flags[3]), .ex_n_flag(tb_flags[2]),
    .ex_c_flag(tb_flags[1]), .ex_v_flag(tb_flags[0]),
    .busy(busy)
  );

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0, a1, b1, imm;
    logic [3:0]  ctrl;
    logic        src;
    logic [3:0]  flg;
    logic        g;       // expected granted requester
    logic [31:0] res;     // hand-computed result of the granted requester
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic v0, input logic v1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] imm, input logic [3:0] ctrl,
                           input logic src);
    req_valid_0 = v0;  req_valid_1 = v1;
    req_a_0 = a0;      req_b_0 = b0;
    req_a_1 = a1;      req_b_1 = b1;
    req_imm_0 = imm;   req_imm_1 = imm;
    req_ctrl_0 = ctrl; req_ctrl_1 = ctrl;
    req_src_0 = src;   req_src_1 = src;
  endtask

  logic [31:0] held_res;
  logic        exp_g;

  initial begin
    //            v0    v1    a0            b0            a1            b1            imm    ctrl  src   flg      g     res
    vt[0] = '{1'b1, 1'b0, 32'd5,        32'd7,        32'd0,        32'd0,        32'd0, 4'h2, 1'b0, 4'b0000, 1'b0, 32'd12};
    vt[1] = '{1'b0, 1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 32'd9,        32'd1, 4'h2, 1'b1, 4'b1010, 1'b1, 32'd0};
    vt[2] = '{1'b1, 1'b1, 32'd100,      32'd23,       32'd50,       32'd50,       32'd0, 4'h3, 1'b0, 4'b0000, 1'b0, 32'd123};
    vt[3] = '{1'b1, 1'b1, 32'd1,        32'd1,        32'h80000000, 32'h80000000, 32'd0, 4'h5, 1'b0, 4'b1011, 1'b1, 32'd0};
    vt[4] = '{1'b0, 1'b1, 32'd0,        32'd0,        32'd10,       32'hFFFFFFFD, 32'd0, 4'h7, 1'b0, 4'b0010, 1'b1, 32'd7};
    vt[5] = '{1'b1, 1'b1, 32'd1,        32'd2,        32'd4,        32'd4,        32'd0, 4'h1, 1'b0, 4'b0000, 1'b0, 32'd3};
    vt[6] = '{1'b0, 1'b1, 32'd0,        32'd0,        32'd2,        32'd99,       32'd3, 4'hA, 1'b1, 4'b0001, 1'b1, 32'd5};

    // Reset held two cycles with both requesters valid.
    rst = 1'b1;
    tb_flags = 4'b0000;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    drive_req(1'b1, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 4'hF, 1'b1);
    @(negedge clk);
    chk("rst_ready0", {31'd0, req_ready_0}, 32'd0);
    chk("rst_ready1", {31'd0, req_ready_1}, 32'd0);
    @(negedge clk);
    chk("rst_ready0_b", {31'd0, req_ready_0}, 32'd0);
    chk("rst_ready1_b", {31'd0, req_ready_1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    chk("rst_ex_data1", ex_reg_data1, 32'd0);
    chk("rst_ex_data2", ex_reg_data2, 32'd0);
    chk("rst_ex_imm", ex_imm_ext, 32'd0);
    chk("rst_ex_ctrl_src", {27'd0, ex_ALUctrl, ex_ALUsrc}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("post_rst_ready1", {31'd0, req_ready_1}, 32'd0);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clk);

    // Table of single operations: grant, operand registering, result capture.
    for (int i = 0; i < 7; i++) begin
      tb_flags = vt[i].flg;
      drive_req(vt[i].v0, vt[i].v1, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1,
                vt[i].imm, vt[i].ctrl, vt[i].src);
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, req_ready_0}, {31'd0, !vt[i].g});
      chk($sformatf("v%0d_ready1", i), {31'd0, req_ready_1}, {31'd0, vt[i].g});
      @(negedge clk);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      chk($sformatf("v%0d_exec_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_ex_data1", i), ex_reg_data1, vt[i].g ? vt[i].a1 : vt[i].a0);
      chk($sformatf("v%0d_ex_data2", i), ex_reg_data2, vt[i].g ? vt[i].b1 : vt[i].b0);
      chk($sformatf("v%0d_ex_imm", i), ex_imm_ext, vt[i].imm);
      chk($sformatf("v%0d_ex_ctrl", i), {28'd0, ex_ALUctrl}, {28'd0, vt[i].ctrl});
      chk($sformatf("v%0d_ex_src", i), {31'd0, ex_ALUsrc}, {31'd0, vt[i].src});
      chk($sformatf("v%0d_exec_rsp_valid", i), {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid0", i), {31'd0, rsp_valid_0}, {31'd0, !vt[i].g});
      chk($sformatf("v%0d_rsp_valid1", i), {31'd0, rsp_valid_1}, {31'd0, vt[i].g});
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vt[i].res);
      chk($sformatf("v%0d_rsp_flags", i), {28'd0, rsp_flags}, {28'd0, vt[i].flg});
      chk($sformatf("v%0d_resp_ready", i), {30'd0, req_ready_1, req_ready_0}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
    end

    // Round-robin: both requesters hold valid; prio is 0 after the last vector.
    tb_flags = 4'b0000;
    drive_req(1'b1, 1'b1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 4'h0, 1'b0);
    exp_g = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (cyc % 3 == 0) begin
        chk($sformatf("rr%0d_ready0", cyc), {31'd0, req_ready_0}, {31'd0, !exp_g});
        chk($sformatf("rr%0d_ready1", cyc), {31'd0, req_ready_1}, {31'd0, exp_g});
        chk($sformatf("rr%0d_busy", cyc), {31'd0, busy}, 32'd0);
        exp_g = ~exp_g;
      end else begin
        chk($sformatf("rr%0d_no_grant", cyc), {30'd0, req_ready_1, req_ready_0}, 32'd0);
        chk($sformatf("rr%0d_busy", cyc), {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;

    // Backpressure on requester 0 while requester 1 waits; prio is 0 again.
    tb_flags = 4'b0100;
    drive_req(1'b1, 1'b1, 32'd40, 32'd2, 32'd9, 32'd1, 32'd0, 4'h2, 1'b0);
    rsp_ready_0 = 1'b0;
    #1;
    chk("bp_grant0", {31'd0, req_ready_0}, 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    @(negedge clk);
    held_res = 32'd42;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_rsp_valid0", k), {31'd0, rsp_valid_0}, 32'd1);
      chk($sformatf("bp%0d_rsp_valid1", k), {31'd0, rsp_valid_1}, 32'd0);
      chk($sformatf("bp%0d_result", k), rsp_result, held_res);
      chk($sformatf("bp%0d_flags", k), {28'd0, rsp_flags}, 32'd4);
      chk($sformatf("bp%0d_ready1", k), {31'd0, req_ready_1}, 32'd0);
      @(negedge clk);
    end
    rsp_ready_0 = 1'b1;
    chk("bp_release_valid0", {31'd0, rsp_valid_0}, 32'd1);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    chk("bp_grant1_ready1", {31'd0, req_ready_1}, 32'd1);
    chk("bp_grant1_ready0", {31'd0, req_ready_0}, 32'd0);
    @(negedge clk);
    req_valid_1 = 1'b0;
    chk("bp_req1_ex_data1", ex_reg_data1, 32'd9);
    @(negedge clk);
    chk("bp_req1_rsp_valid1", {31'd0, rsp_valid_1}, 32'd1);
    chk("bp_req1_result", rsp_result, 32'd10);
    @(negedge clk);

    // Reset during EXEC: requester 0 granted (prio becomes 1), then reset.
    drive_req(1'b1, 1'b0, 32'd7, 32'd8, 32'd3, 32'd3, 32'd0, 4'h6, 1'b1);
    @(negedge clk);
    chk("rmo_exec_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1;
    chk("rmo_rst_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    @(negedge clk);
    chk("rmo_busy", {31'd0, busy}, 32'd0);
    chk("rmo_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    chk("rmo_ex_data1", ex_reg_data1, 32'd0);
    chk("rmo_ex_data2", ex_reg_data2, 32'd0);
    chk("rmo_ex_ctrl_src", {27'd0, ex_ALUctrl, ex_ALUsrc}, 32'd0);
    chk("rmo_result", rsp_result, 32'd0);
    chk("rmo_rst_ready_b", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rmo_prio_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("rmo_prio_ready1", {31'd0, req_ready_1}, 32'd0);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rmo%0d_no_rsp", k), {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `execute` stage (operand mux + ALU) between two requesters, e.g. the integer pipeline and the address-generation path. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and registers operands into the execute stage. It captures the combinational ALU result and flags one cycle later and holds them until the owner accepts them. Only one operation is outstanding at a time.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid_0`, `req_valid_1`  in  1  request present
- `req_ready_0`, `req_ready_1`  out  1  request accepted this cycle (combinational)
- `req_a_0`, `req_a_1`  in  DATA_WIDTH  first operand (reg_data1)
- `req_b_0`, `req_b_1`  in  DATA_WIDTH  second operand (reg_data2)
- `req_imm_0`, `req_imm_1`  in  DATA_WIDTH  extended immediate
- `req_ctrl_0`, `req_ctrl_1`  in  4  ALUctrl code
- `req_src_0`, `req_src_1`  in  1  ALUsrc; 1 selects immediate
- `rsp_valid_0`, `rsp_valid_1`  out  1  result available for that requester
- `rsp_ready_0`, `rsp_ready_1`  in  1  requester accepts result
- `rsp_result`  out  DATA_WIDTH  captured ALU result (shared by both)
- `rsp_flags`  out  4  captured {z, n, c, v}
- `ex_reg_data1`, `ex_reg_data2`, `ex_imm_ext`  out  DATA_WIDTH  registered operands to execute stage
- `ex_ALUctrl`  out  4  registered ALU control
- `ex_ALUsrc`  out  1  registered operand select
- `ex_alu_result`  in  DATA_WIDTH  execute stage result
- `ex_z_flag`, `ex_n_flag`, `ex_c_flag`, `ex_v_flag`  in  1  execute stage flags
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. `owner` register (1 bit) holds the granted requester. `prio` register (1 bit) is the requester favoured on a tie.
- IDLE:
  - If only one `req_valid_x` is high, grant x.
  - If both are high, grant `prio`.
  - `req_ready_x` is high only for the granted x, only in IDLE. Both are 0 in EXEC and RESP regardless of valid.
  - On handshake: latch `req_a/b/imm/ctrl/src` of x into the `ex_*` registers, set `owner=x`, set `prio=~x`, go to EXEC.
- EXEC: capture `ex_alu_result` into `rsp_result` and {z,n,c,v} into `rsp_flags` at the end of the cycle, then go to RESP.
- RESP:
  - `rsp_valid_owner=1`; the other `rsp_valid` stays 0.
  - On `rsp_ready_owner`, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `ex_*`, `rsp_result` and `rsp_flags` hold their last values in all states; they change only on a new grant or capture respectively.
- No arithmetic inside the block. Operands, ctrl and src pass through unmodified at full width.
- A requester may change or drop `req_valid` while not granted; no request is lost or duplicated. Grant is decided only on the cycle of the handshake.

## Timing
- Reset values:
  - State IDLE, `owner=0`, `prio=0`.
  - All `ex_*` outputs 0, `rsp_result=0`, `rsp_flags=0`.
  - `rsp_valid_*=0`, `busy=0`.
- `req_ready_*` is combinational from state, `req_valid_*` and `prio`.
- Latency:
  - Handshake at edge T.
  - `ex_*` valid in cycle T+1 (EXEC).
  - Result captured at edge T+1.
  - `rsp_valid` high from cycle T+2.
- With `rsp_ready` held high, the minimum spacing between grants is 3 cycles: IDLE, EXEC, RESP.
- Response is held stable indefinitely under backpressure (`rsp_ready=0`).
- `rst` asserted in any state takes effect at the next edge:
  - The in-flight operation is discarded and no response is issued.
  - Both `req_ready_*` are 0 while `rst` is high.

## Test plan
- Reset: hold `rst` 2 cycles with both `req_valid` high -> `req_ready_*=0`, all outputs 0. First grant after release goes to requester 0 (`prio=0`).
- Single op (bench models the ALU as `ex_alu_result = ex_reg_data1 + (ex_ALUsrc ? ex_imm_ext : ex_reg_data2)`):
  - Stimulus: req0 a=5, b=7, src=0, ctrl=4'h2.
  - Required: `ex_ALUctrl=4'h2` in T+1; `rsp_valid_0=1`, `rsp_result=12` in T+2; `rsp_valid_1=0`.
- Immediate select: req1 a=32'hFFFFFFFF, imm=1, src=1 -> `ex_ALUsrc=1`, `rsp_result=0`. `rsp_flags` equals bench-driven ex flags (e.g. z=1, c=1 -> 4'b1010).
- Round-robin: both requesters hold valid for 4 ops with `rsp_ready` high -> grants alternate 0,1,0,1, one grant every 3 cycles, no grant while `busy`.
- Backpressure: `rsp_ready_0=0` for 5 cycles after the response appears -> `rsp_valid_0` and `rsp_result` are stable, `req_ready_1` stays 0. On release, return to IDLE and grant req1 the next cycle.
- Reset mid-op: assert `rst` during EXEC -> no `rsp_valid` pulse, `prio=0`, `ex_*=0` after the edge.
